// File: rtl/toggle_sync_rx_multi_pkg.sv
// Shared constants and types for the multi-channel toggle/level event synchroniser.
// Holds the edge-mode selectors, the arming state encoding and the edge-detect helper.
package toggle_sync_pkg;

    localparam int EDGE_ANY  = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    typedef enum logic {
        ST_ARMING = 1'b0,
        ST_RUN    = 1'b1
    } arm_state_t;

    // Compares the synchronised sample against the previous one for the chosen edge kind.
    function automatic logic detect_edge(input int mode, input logic cur, input logic prev);
        logic hit;
        case (mode)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            default:   hit = cur ^ prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/toggle_sync_rx_multi_if.sv
// Bundles the per-channel inputs and event outputs of the receive synchroniser.
// The consumer side uses master; the synchroniser itself uses slave.
interface toggle_sync_rx_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);

    logic [CHANNELS-1:0]       async_in;
    logic [CHANNELS-1:0]       evt_ack;
    logic [CHANNELS-1:0]       clr;
    logic                      armed;
    logic [CHANNELS-1:0]       evt_pulse;
    logic [CHANNELS-1:0]       evt_pend;
    logic [CHANNELS-1:0]       evt_ovf;
    logic [CHANNELS*CNT_W-1:0] evt_cnt;

    modport master (
        output async_in, evt_ack, clr,
        input  armed, evt_pulse, evt_pend, evt_ovf, evt_cnt
    );

    modport slave (
        input  async_in, evt_ack, clr,
        output armed, evt_pulse, evt_pend, evt_ovf, evt_cnt
    );

endinterface

// File: rtl/toggle_sync_rx_multi_chan.sv
// One receive channel: synchroniser chain, edge detect, pending/overflow flags and
// a saturating event counter. Events are only honoured once the shared armed flag is up.
module toggle_sync_chan
    import toggle_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int EDGE_MODE   = EDGE_ANY,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             async_in,
    input  logic             armed,
    input  logic             ack,
    input  logic             clr,
    output logic             evt_pulse,
    output logic             pend,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic hist_q;
    logic evt;

    // The chain and history keep shifting while disarmed so they settle before RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt       = armed & detect_edge(EDGE_MODE, sync_q[SYNC_STAGES-1], hist_q);
    assign evt_pulse = evt;

    // A new event beats a simultaneous ack or clear so nothing is silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
            cnt  <= '0;
        end else begin
            if (evt)
                pend <= 1'b1;
            else if (ack)
                pend <= 1'b0;

            if (evt && pend && !ack)
                ovf <= 1'b1;
            else if (clr)
                ovf <= 1'b0;

            if (clr)
                cnt <= evt ? CNT_W'(1) : '0;
            else if (evt && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/toggle_sync_rx_multi.sv
// Multi-channel receive-side event synchroniser: shared arming FSM plus one
// toggle_sync_chan per channel, packed onto the interface.
module toggle_sync_rx_multi
    import toggle_sync_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 3,
    parameter int EDGE_MODE   = EDGE_ANY,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toggle_sync_rx_multi_if.slave bus
);

    localparam int              ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    arm_state_t       state_q, state_nxt;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_nxt;
    logic             armed;

    logic [CHANNELS-1:0]       pulse_vec, pend_vec, ovf_vec;
    logic [CHANNELS*CNT_W-1:0] cnt_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARMING;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            arm_cnt_q <= arm_cnt_nxt;
        end
    end

    // Stay disarmed until the chain and history have flushed any value present at reset release.
    always_comb begin
        state_nxt   = state_q;
        arm_cnt_nxt = arm_cnt_q;
        case (state_q)
            ST_ARMING: begin
                if (arm_cnt_q == ARM_LAST)
                    state_nxt = ST_RUN;
                else
                    arm_cnt_nxt = arm_cnt_q + ARM_W'(1);
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign armed = (state_q == ST_RUN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        toggle_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_in  (bus.async_in[i]),
            .armed     (armed),
            .ack       (bus.evt_ack[i]),
            .clr       (bus.clr[i]),
            .evt_pulse (pulse_vec[i]),
            .pend      (pend_vec[i]),
            .ovf       (ovf_vec[i]),
            .cnt       (cnt_vec[i*CNT_W +: CNT_W])
        );
    end

    assign bus.armed     = armed;
    assign bus.evt_pulse = pulse_vec;
    assign bus.evt_pend  = pend_vec;
    assign bus.evt_ovf   = ovf_vec;
    assign bus.evt_cnt   = cnt_vec;

endmodule

// File: tb/tb_toggle_sync_rx_multi.sv
// Bench for toggle_sync_rx_multi: an ANY-edge/2-bit-counter instance and a RISE-edge/4-bit
// instance share stimulus and are compared every cycle against a delay-based reference model.
module tb_toggle_sync_rx_multi;

    localparam int N  = 3;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [CH-1:0] ain = '0;
    logic [CH-1:0] ack = '0;
    logic [CH-1:0] clr = '0;

    int n_checks = 0;
    int n_err    = 0;

    toggle_sync_rx_multi_if #(.CHANNELS(CH), .CNT_W(2)) bus_a ();
    toggle_sync_rx_multi_if #(.CHANNELS(CH), .CNT_W(4)) bus_b ();

    assign bus_a.async_in = ain;
    assign bus_a.evt_ack  = ack;
    assign bus_a.clr      = clr;
    assign bus_b.async_in = ain;
    assign bus_b.evt_ack  = ack;
    assign bus_b.clr      = clr;

    toggle_sync_rx_multi #(.CHANNELS(CH), .SYNC_STAGES(N), .EDGE_MODE(0), .CNT_W(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    toggle_sync_rx_multi #(.CHANNELS(CH), .SYNC_STAGES(N), .EDGE_MODE(1), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Reference model: input sampled at each edge since reset, plus per-instance event state.
    int            edge_n;
    logic [CH-1:0] in_hist[$];
    int            last_chg[CH];
    logic [CH-1:0] m_pulse[2];
    logic [CH-1:0] m_pend[2];
    logic [CH-1:0] m_ovf[2];
    int            m_cnt[2][CH];
    int            cnt_max[2] = '{3, 15};
    int            mode[2]    = '{0, 1};

    function automatic logic [CH-1:0] in_at(input int k);
        if (k < 1 || k > in_hist.size())
            return '0;
        return in_hist[k-1];
    endfunction

    task automatic model_reset();
        edge_n = 0;
        in_hist.delete();
        for (int d = 0; d < 2; d++) begin
            m_pulse[d] = '0;
            m_pend[d]  = '0;
            m_ovf[d]   = '0;
            for (int i = 0; i < CH; i++) m_cnt[d][i] = 0;
        end
        for (int i = 0; i < CH; i++) last_chg[i] = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] cur, prev;
        edge_n++;
        in_hist.push_back(ain);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                if (m_pulse[d][i] && m_pend[d][i] && !ack[i])
                    m_ovf[d][i] = 1'b1;
                else if (clr[i])
                    m_ovf[d][i] = 1'b0;
                if (m_pulse[d][i])
                    m_pend[d][i] = 1'b1;
                else if (ack[i])
                    m_pend[d][i] = 1'b0;
                if (clr[i])
                    m_cnt[d][i] = m_pulse[d][i] ? 1 : 0;
                else if (m_pulse[d][i] && m_cnt[d][i] < cnt_max[d])
                    m_cnt[d][i] = m_cnt[d][i] + 1;
            end
        end
        // The change applied before edge E becomes visible as a pulse after edge E+N-1.
        cur  = in_at(edge_n - N + 1);
        prev = in_at(edge_n - N);
        for (int d = 0; d < 2; d++) begin
            if (edge_n < N + 1)
                m_pulse[d] = '0;
            else if (mode[d] == 1)
                m_pulse[d] = cur & ~prev;
            else
                m_pulse[d] = cur ^ prev;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [CH-1:0] o_pulse[2], o_pend[2], o_ovf[2];
        logic          o_armed[2];
        int            o_cnt[2][CH];
        o_pulse[0] = bus_a.evt_pulse; o_pulse[1] = bus_b.evt_pulse;
        o_pend[0]  = bus_a.evt_pend;  o_pend[1]  = bus_b.evt_pend;
        o_ovf[0]   = bus_a.evt_ovf;   o_ovf[1]   = bus_b.evt_ovf;
        o_armed[0] = bus_a.armed;     o_armed[1] = bus_b.armed;
        for (int i = 0; i < CH; i++) begin
            o_cnt[0][i] = int'(bus_a.evt_cnt[i*2 +: 2]);
            o_cnt[1][i] = int'(bus_b.evt_cnt[i*4 +: 4]);
        end
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("%s e%0d d%0d armed", where, edge_n, d),
                         32'(o_armed[d]), 32'(edge_n >= N + 1));
            check_output($sformatf("%s e%0d d%0d pulse", where, edge_n, d),
                         32'(o_pulse[d]), 32'(m_pulse[d]));
            check_output($sformatf("%s e%0d d%0d pend", where, edge_n, d),
                         32'(o_pend[d]), 32'(m_pend[d]));
            check_output($sformatf("%s e%0d d%0d ovf", where, edge_n, d),
                         32'(o_ovf[d]), 32'(m_ovf[d]));
            for (int i = 0; i < CH; i++)
                check_output($sformatf("%s e%0d d%0d cnt%0d", where, edge_n, d, i),
                             32'(o_cnt[d][i]), 32'(m_cnt[d][i]));
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_steps(input int n);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < CH; i++) begin
                if (edge_n - last_chg[i] >= N + 2 && $urandom_range(0, 3) == 0) begin
                    ain[i]      = ~ain[i];
                    last_chg[i] = edge_n;
                end
                ack[i] = ($urandom_range(0, 2) == 0);
                clr[i] = ($urandom_range(0, 9) == 0);
            end
            apply_stimulus();
        end
        ack = '0;
        clr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;

        ain = 4'b1111;
        #2;
        apply_reset();
        repeat (8) apply_stimulus();
        check_output("armed after window", 32'(bus_a.armed), 32'd1);
        check_output("no spurious pend", 32'(bus_a.evt_pend), 32'd0);

        ain = '0;
        #1;
        apply_reset();
        repeat (6) apply_stimulus();

        ain[0] = 1'b1;
        repeat (6) apply_stimulus();
        check_output("ch0 cnt", 32'(bus_a.evt_cnt[1:0]), 32'd1);

        ain[1] = ~ain[1];
        repeat (8) apply_stimulus();
        ain[1] = ~ain[1];
        repeat (8) apply_stimulus();
        check_output("ch1 ovf", 32'(bus_a.evt_ovf[1]), 32'd1);
        check_output("ch1 cnt", 32'(bus_a.evt_cnt[3:2]), 32'd2);
        clr[1] = 1'b1;
        apply_stimulus();
        clr = '0;
        check_output("ch1 cnt after clr", 32'(bus_a.evt_cnt[3:2]), 32'd0);
        check_output("ch1 pend after clr", 32'(bus_a.evt_pend[1]), 32'd1);
        repeat (2) apply_stimulus();

        ain[2] = ~ain[2];
        repeat (6) apply_stimulus();
        ain[2] = ~ain[2];
        for (int k = 0; k < 10 && !m_pulse[0][2]; k++) apply_stimulus();
        check_output("ch2 pulse seen", 32'(bus_a.evt_pulse[2]), 32'd1);
        ack[2] = 1'b1;
        apply_stimulus();
        ack = '0;
        check_output("ch2 pend kept", 32'(bus_a.evt_pend[2]), 32'd1);
        check_output("ch2 no ovf", 32'(bus_a.evt_ovf[2]), 32'd0);
        repeat (2) apply_stimulus();

        repeat (5) begin
            ain[3] = ~ain[3];
            repeat (5) apply_stimulus();
        end
        check_output("ch3 saturated", 32'(bus_a.evt_cnt[7:6]), 32'd3);
        ain[3] = ~ain[3];
        for (int k = 0; k < 10 && !m_pulse[0][3]; k++) apply_stimulus();
        check_output("ch3 pulse seen", 32'(bus_a.evt_pulse[3]), 32'd1);
        clr[3] = 1'b1;
        apply_stimulus();
        clr = '0;
        check_output("ch3 clr with evt", 32'(bus_a.evt_cnt[7:6]), 32'd1);
        repeat (2) apply_stimulus();

        // Rising-only instance must produce one pulse for a full 0->1->0 cycle.
        ain[0] = 1'b0;
        repeat (6) apply_stimulus();
        pulses = 0;
        ain[0] = 1'b1;
        repeat (6) begin apply_stimulus(); pulses += int'(bus_b.evt_pulse[0]); end
        ain[0] = 1'b0;
        repeat (6) begin apply_stimulus(); pulses += int'(bus_b.evt_pulse[0]); end
        check_output("rise single pulse", 32'(pulses), 32'd1);

        ain[0] = 1'b1;
        repeat (2) apply_stimulus();
        apply_reset();
        repeat (6) apply_stimulus();

        random_steps(400);
        apply_reset();
        random_steps(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
